// File: rtl/pipe_reg_pkg.sv
// Shared definitions for the pipe_reg valid/ready stage: occupancy states and count width.
package pipe_reg_pkg;

    localparam int unsigned PIPE_CNT_W = 2;

    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_ONE   = 2'd1,
        PIPE_TWO   = 2'd2
    } pipe_state_t;

    function automatic logic [PIPE_CNT_W-1:0] pipe_state_count(input pipe_state_t s);
        case (s)
            PIPE_ONE: return PIPE_CNT_W'(1);
            PIPE_TWO: return PIPE_CNT_W'(2);
            default:  return '0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_reg_dff.sv
// Enable flip-flop with synchronous active-high reset to a parameterised value.
module dff #(
    parameter int unsigned           WIDTH     = 1,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_reg.sv
// Valid/ready pipeline register with 1-cycle latency; define PIPE_SKID_EN for a
// two-entry skid buffer with a registered in_ready, otherwise a single entry stage.
module pipe_reg
    import pipe_reg_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [PIPE_CNT_W-1:0] count
);

    pipe_state_t           r_state;
    pipe_state_t           w_state_nxt;
    logic [PIPE_CNT_W-1:0] r_count;
    logic                  w_in_xfer;
    logic                  w_out_xfer;
    logic                  w_main_en;
    logic [DATA_WIDTH-1:0] w_main_d;
`ifdef PIPE_SKID_EN
    logic                  w_skid_en;
    logic [DATA_WIDTH-1:0] w_skid_q;
`endif

    assign out_valid = (r_state != PIPE_EMPTY);
    assign count     = r_count;
`ifdef PIPE_SKID_EN
    assign in_ready  = (r_count != PIPE_CNT_W'(2));
`else
    assign in_ready  = !out_valid || out_ready;
`endif

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_en   = 1'b0;
        w_main_d    = in_data;
`ifdef PIPE_SKID_EN
        w_skid_en   = 1'b0;
`endif
        case (r_state)
            PIPE_EMPTY: begin
                if (w_in_xfer) begin
                    w_state_nxt = PIPE_ONE;
                    w_main_en   = 1'b1;
                end
            end
            PIPE_ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_main_en = 1'b1;
                end else if (w_out_xfer) begin
                    w_state_nxt = PIPE_EMPTY;
`ifdef PIPE_SKID_EN
                end else if (w_in_xfer) begin
                    w_state_nxt = PIPE_TWO;
                    w_skid_en   = 1'b1;
`endif
                end
            end
`ifdef PIPE_SKID_EN
            PIPE_TWO: begin
                if (w_out_xfer) begin
                    w_state_nxt = PIPE_ONE;
                    w_main_en   = 1'b1;
                    w_main_d    = w_skid_q;
                end
            end
`endif
            default: w_state_nxt = PIPE_EMPTY;
        endcase
        // Flush drops valid state only; gating the enables keeps payload registers untouched.
        if (flush) begin
            w_state_nxt = PIPE_EMPTY;
            w_main_en   = 1'b0;
`ifdef PIPE_SKID_EN
            w_skid_en   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= PIPE_EMPTY;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= pipe_state_count(w_state_nxt);
        end
    end

    dff #(
        .WIDTH     (DATA_WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk (clk),
        .rst (rst),
        .en  (w_main_en),
        .d   (w_main_d),
        .q   (out_data)
    );

`ifdef PIPE_SKID_EN
    dff #(
        .WIDTH     (DATA_WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (w_skid_en),
        .d   (in_data),
        .q   (w_skid_q)
    );
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// Scoreboard bench for pipe_reg (DATA_WIDTH=8, RESET_VAL=8'hA5); follows PIPE_SKID_EN.
module tb_pipe_reg;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] count;

    int unsigned n_checks;
    int unsigned n_fail;
    logic [7:0]  q_exp[$];

    pipe_reg #(
        .DATA_WIDTH (8),
        .RESET_VAL  (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: check outputs against the model mid-cycle, then update the model at the edge.
    task automatic tick();
        logic       exp_rdy;
        logic       in_x;
        logic       out_x;
        logic [7:0] d;
        int unsigned occ;
        @(negedge clk);
        occ = q_exp.size();
`ifdef PIPE_SKID_EN
        exp_rdy = (occ != 2);
`else
        exp_rdy = (occ == 0) || out_ready;
`endif
        if (!rst) begin
            check("in_ready", 32'(in_ready), 32'(exp_rdy));
            check("out_valid", 32'(out_valid), 32'(occ != 0));
            check("count", 32'(count), occ);
            if (occ != 0) check("out_data", 32'(out_data), 32'(q_exp[0]));
        end
        in_x  = in_valid && exp_rdy;
        out_x = (occ != 0) && out_ready;
        d     = in_data;
        @(posedge clk);
        if (rst || flush) begin
            q_exp.delete();
        end else begin
            if (out_x) void'(q_exp.pop_front());
            if (in_x) q_exp.push_back(d);
        end
        #1;
    endtask

    task automatic do_reset(input int unsigned cycles);
        rst = 1'b1;
        repeat (cycles) tick();
        rst = 1'b0;
        check("rst_out_data", 32'(out_data), 32'h0000_00A5);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
    endtask

    task automatic fill_two();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        tick();
        in_data   = 8'h22;
        tick();
        in_valid  = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        do_reset(2);
        tick();

        // Back-to-back streaming
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();

        // Backpressure, then drain
        fill_two();
        repeat (2) tick();
        out_ready = 1'b1;
        repeat (3) tick();

        // Flush with a competing input and output transfer
        fill_two();
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h33;
        out_ready = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_data_kept", 32'(out_data), 32'h0000_0011);
        repeat (3) tick();

        // Reset while full with an input offered
        fill_two();
        in_valid = 1'b1;
        in_data  = 8'h44;
        do_reset(1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();

        // Randomised traffic with occasional flush
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            tick();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 Parameter DATA_WIDTH, default 32: payload width in bits, minimum 1.
REQ-002 Parameter RESET_VAL, default 0: value loaded into every data register on reset.
REQ-003 Port clk  input  1: single clock; all state updates on posedge clk.
REQ-004 Port rst  input  1: synchronous, active-high reset.
REQ-005 Port flush  input  1: synchronous discard of all held entries.
REQ-006 Port in_valid  input  1: upstream offers in_data.
REQ-007 Port in_ready  output  1: stage accepts; transfer occurs when in_valid && in_ready at posedge.
REQ-008 Port in_data  input  DATA_WIDTH: upstream payload.
REQ-009 Port out_valid  output  1: out_data holds a valid entry.
REQ-010 Port out_ready  input  1: downstream accepts; transfer occurs when out_valid && out_ready at posedge.
REQ-011 Port out_data  output  DATA_WIDTH: head entry payload, driven directly from a register.
REQ-012 Port count  output  2: number of held entries, 0..2.

Function
REQ-013 The stage SHALL be a valid/ready pipeline register with 1-cycle latency: an entry accepted at edge N appears on out_valid/out_data after edge N, never in the same cycle.
REQ-014 The stage SHALL preserve order, never duplicate, and never drop an accepted entry except on flush or rst.
REQ-015 The stage SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-016 The stage SHALL use states EMPTY (count=0), ONE (count=1, main only), TWO (count=2, main+skid); TWO exists only with PIPE_SKID_EN.
REQ-017 Transitions: EMPTY->ONE on input transfer; ONE->EMPTY on output-only transfer; ONE->ONE on simultaneous in/out transfer, new entry into main; ONE->TWO on input transfer without output transfer, entry into skid; TWO->ONE on output transfer, skid moves to main.
REQ-018 In TWO, in_ready SHALL be 0, so no input transfer occurs.
REQ-019 flush SHALL force state EMPTY and count 0 at the next edge, overriding any same-cycle input or output transfer; the entry offered in the flush cycle is discarded.
REQ-020 flush SHALL clear valid bits only; data registers keep their contents.
REQ-021 count SHALL be registered and equal the number of valid entries at all times.

Reset
REQ-022 With rst=1 at posedge: out_valid=0, count=0, main and skid data=RESET_VAL, state EMPTY.
REQ-023 rst SHALL take priority over flush and all transfers, including mid-operation in state TWO.
REQ-024 in_ready SHALL be 1 in the cycle after reset is released.

Configuration
REQ-025 Macro PIPE_SKID_EN defined: two-entry skid buffer; in_ready = (count != 2), a pure register output with no combinational path from out_ready; full throughput of one transfer per cycle.
REQ-026 PIPE_SKID_EN undefined: skid register and state TWO absent; in_ready = !out_valid || out_ready (combinational); count never exceeds 1; all other requirements unchanged.

Structure
REQ-027 A shared package SHALL hold the state enum (PIPE_EMPTY, PIPE_ONE, PIPE_TWO) and the count width constant.
REQ-028 Data storage SHALL instantiate the team's existing enable flip-flop (dff) for main and skid payloads; no other sub-module.

Verification
REQ-029 Reset: rst=1 for 2 cycles, DATA_WIDTH=8, RESET_VAL=8'hA5 -> out_valid=0, count=0, out_data=8'hA5, in_ready=1 after release.
REQ-030 Streaming: out_ready=1, send 0x01..0x10 back-to-back -> 16 outputs in order, each one cycle after acceptance, in_ready never drops.
REQ-031 Backpressure (PIPE_SKID_EN): out_ready=0, send 0x11,0x22 -> count=2, in_ready=0, out_data=0x11 stable; raise out_ready -> 0x11 then 0x22, count 2->1->0.
REQ-032 Flush: count=2, flush=1 with in_valid=1/in_data=0x33 and out_ready=1 -> next cycle count=0, out_valid=0; 0x33 never appears at the output.
REQ-033 Reset mid-operation: state TWO, rst=1 with in_valid=1 -> count=0, out_data=RESET_VAL; no stale entry emerges afterwards.
REQ-034 No-skid build: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle; out_ready=1 -> in_ready=1 combinationally, count never exceeds 1.
